dcache_direct_wb: RTL

- Direct-mapped, write-back, write-allocate data cache. It is the responder on the CPU pipeline's DCACHE interface (ren/wen/addr/wdata in; stall/rdata out).
- Fronts a slow line-wide memory through a request/ready handshake.
- Sits between the pipeline's MEM stage and main memory. Data passes through unmodified; byte swapping stays in the CPU.

---
 rtl/dcache_direct_wb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped, write-back, write-allocate data cache
//
// Responder on the CPU DCACHE interface, fronting a slow line-wide memory.
// Lines are 4 x 32-bit words; LINES = 2**INDEX_W; tag = proc_addr[29:INDEX_W+2].
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   proc_read         CPU load request
//   proc_write        CPU store request (wins if both are asserted)
//   proc_addr[29:0]   word address: [1:0] word, [INDEX_W+1:2] index, rest tag
//   proc_wdata[31:0]  store data
//   proc_stall        CPU must hold its request
//   proc_rdata[31:0]  load data, valid when proc_read=1 and proc_stall=0
//   mem_read          line fill request
//   mem_write         line write-back request
//   mem_addr[27:0]    line address
//   mem_wdata[127:0]  victim line, word0 in [31:0]
//   mem_ready         one-cycle completion pulse
//   mem_rdata[127:0]  fill line, valid with mem_ready, word0 in [31:0]
module dcache_direct_wb #(
   parameter int INDEX_W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [127:0] mem_rdata
);

   localparam int LINES = 2**INDEX_W;
   localparam int TAG_W = 28 - INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_ALLOC
   } state_t;

   state_t state, state_nxt;

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [127:0]     data_q [LINES];

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   req_tag;
   logic [1:0]         word_sel;
   logic [127:0]       line_sel;
   logic               req;
   logic               hit;
   logic               victim_dirty;
   logic               store_hit;
   logic               fill_done;

   assign idx          = proc_addr[INDEX_W+1:2];
   assign req_tag      = proc_addr[29:INDEX_W+2];
   assign word_sel     = proc_addr[1:0];
   assign req          = proc_read | proc_write;
   assign line_sel     = data_q[idx];
   assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
   assign victim_dirty = valid_q[idx] & dirty_q[idx];

   // The selected word is always presented; it only matters on a read hit.
   assign proc_rdata = line_sel[{word_sel, 5'b0} +: 32];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The cache holds no copy of the CPU request: the CPU keeps proc_addr
   // stable while stalled, so WB/ALLOC address everything through it.
   always_comb begin
      state_nxt  = state;
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      store_hit  = 1'b0;
      fill_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (hit) begin
                  store_hit = proc_write;
               end else begin
                  proc_stall = 1'b1;
                  state_nxt  = victim_dirty ? S_WB : S_ALLOC;
               end
            end
         end
         S_WB: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {tag_q[idx], idx};
            mem_wdata  = line_sel;
            // Dirty bit stays set here; the fill that follows clears it.
            if (mem_ready) begin
               state_nxt = S_ALLOC;
            end
         end
         S_ALLOC: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[29:2];
            // Store data is not merged into the fill: the held request
            // re-evaluates as a hit in IDLE and the store applies then.
            if (mem_ready) begin
               fill_done = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_done) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (fill_done) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= req_tag;
         end else if (store_hit) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= proc_wdata;
         end
      end
   end

endmodule
